// File: rtl/ber_pkg.sv
// Shared definitions for the BER test controller: FSM state encoding and
// the status codes reported when a run finishes.
package ber_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_ACQ,
        S_MEAS,
        S_DONE
    } ber_state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_LOST    = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

endpackage

// File: rtl/ber_test_ctrl_lock_qualifier.sv
// Counts consecutive cycles where lock_i equals polarity_i and flags the
// cycle in which the QUAL-th matching sample arrives.
module lock_qualifier #(
    parameter int QUAL = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic polarity_i,
    input  logic lock_i,
    output logic qualified_o
);

    localparam int CW = $clog2(QUAL + 1);

    logic [CW-1:0] cnt_q;
    logic          match;

    assign match       = (lock_i == polarity_i);
    assign qualified_o = match && (cnt_q == CW'(QUAL - 1));

    // cnt_q holds how many matching samples preceded the current cycle
    always_ff @(posedge clk) begin
        if (reset || clear_i || !match) begin
            cnt_q <= '0;
        end else if (cnt_q != CW'(QUAL - 1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// Sequences a PRBS checker through reset, lock acquisition and a windowed
// error measurement, then reports saturating totals and a status code.
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 32,
    parameter int LOCK_QUAL    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int RST_CYC      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] window_len_i,
    input  logic [WIDTH-1:0] chk_err_num_i,
    input  logic             chk_lock_i,
    output logic             chk_reset_o,
    output logic             chk_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic [CNT_W-1:0] err_total_o,
    output logic [CNT_W-1:0] word_total_o
);

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int AC_W = $clog2(LOCK_TIMEOUT + 1);

    ber_state_e       state_q, state_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] errTotal_q, errTotal_d;
    logic [CNT_W-1:0] wordTotal_q, wordTotal_d;
    logic [CNT_W-1:0] windowLen_q, windowLen_d;
    logic [RC_W-1:0]  rstCnt_q, rstCnt_d;
    logic [AC_W-1:0]  acqCnt_q, acqCnt_d;
    logic             chkReset_q, chkEn_q, busy_q, done_q;

    logic             qualified;
    logic             qualClear;
    logic [CNT_W:0]   errSum;
    logic [CNT_W-1:0] errSat;
    logic [CNT_W-1:0] wordNext;

    // One qualifier serves both lock acquisition and lock-loss detection
    assign qualClear = !(state_q == S_ACQ || state_q == S_MEAS) ||
                       (state_q == S_ACQ && qualified);

    lock_qualifier #(.QUAL(LOCK_QUAL)) u_qual (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (qualClear),
        .polarity_i  (state_q == S_ACQ),
        .lock_i      (chk_lock_i),
        .qualified_o (qualified)
    );

    assign errSum   = {1'b0, errTotal_q} + (CNT_W+1)'(chk_err_num_i);
    assign errSat   = errSum[CNT_W] ? '1 : errSum[CNT_W-1:0];
    assign wordNext = wordTotal_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        errTotal_d  = errTotal_q;
        wordTotal_d = wordTotal_q;
        windowLen_d = windowLen_q;
        rstCnt_d    = rstCnt_q;
        acqCnt_d    = acqCnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i && !abort_i) begin
                    windowLen_d = window_len_i;
                    errTotal_d  = '0;
                    wordTotal_d = '0;
                    status_d    = ST_OK;
                    rstCnt_d    = '0;
                    state_d     = S_RST;
                end
            end
            S_RST: begin
                if (abort_i) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (rstCnt_q == RC_W'(RST_CYC - 1)) begin
                    acqCnt_d = '0;
                    state_d  = S_ACQ;
                end else begin
                    rstCnt_d = rstCnt_q + 1'b1;
                end
            end
            S_ACQ: begin
                if (abort_i) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (qualified) begin
                    status_d = ST_OK;
                    state_d  = (windowLen_q == '0) ? S_DONE : S_MEAS;
                end else if (acqCnt_q == AC_W'(LOCK_TIMEOUT - 1)) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    acqCnt_d = acqCnt_q + 1'b1;
                end
            end
            S_MEAS: begin
                if (abort_i) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else begin
                    errTotal_d  = errSat;
                    wordTotal_d = wordNext;
                    if (wordNext == windowLen_q) begin
                        state_d  = S_DONE;
                        status_d = ST_OK;
                    end else if (qualified) begin
                        state_d  = S_DONE;
                        status_d = ST_LOST;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            errTotal_q  <= '0;
            wordTotal_q <= '0;
            windowLen_q <= '0;
            rstCnt_q    <= '0;
            acqCnt_q    <= '0;
            chkReset_q  <= 1'b1;
            chkEn_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            errTotal_q  <= errTotal_d;
            wordTotal_q <= wordTotal_d;
            windowLen_q <= windowLen_d;
            rstCnt_q    <= rstCnt_d;
            acqCnt_q    <= acqCnt_d;
            chkReset_q  <= (state_d == S_IDLE) || (state_d == S_RST);
            chkEn_q     <= (state_d == S_ACQ) || (state_d == S_MEAS);
            busy_q      <= (state_d == S_RST) || (state_d == S_ACQ) ||
                           (state_d == S_MEAS);
            done_q      <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    assign chk_reset_o  = chkReset_q;
    assign chk_en_o     = chkEn_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign err_total_o  = errTotal_q;
    assign word_total_o = wordTotal_q;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Bench for ber_test_ctrl: expected run results are queued at start and
// compared when the controller pulses done.
module tb_ber_test_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, lock;
    logic [31:0] windowLen;
    logic [7:0]  errNum;
    logic        chkReset, chkEn, busy, done;
    logic [1:0]  status;
    logic [31:0] errTotal, wordTotal;

    logic        start8, abort8, lock8;
    logic [7:0]  windowLen8, errNum8;
    logic        chkReset8, chkEn8, busy8, done8;
    logic [1:0]  status8;
    logic [7:0]  errTotal8, wordTotal8;

    int checks = 0;
    int errors = 0;
    int enCount = 0;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] errs;
        logic [31:0] words;
        int          enCyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    ber_test_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .abort_i      (abort),
        .window_len_i (windowLen),
        .chk_err_num_i(errNum),
        .chk_lock_i   (lock),
        .chk_reset_o  (chkReset),
        .chk_en_o     (chkEn),
        .busy_o       (busy),
        .done_o       (done),
        .status_o     (status),
        .err_total_o  (errTotal),
        .word_total_o (wordTotal)
    );

    ber_test_ctrl #(.CNT_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start8),
        .abort_i      (abort8),
        .window_len_i (windowLen8),
        .chk_err_num_i(errNum8),
        .chk_lock_i   (lock8),
        .chk_reset_o  (chkReset8),
        .chk_en_o     (chkEn8),
        .busy_o       (busy8),
        .done_o       (done8),
        .status_o     (status8),
        .err_total_o  (errTotal8),
        .word_total_o (wordTotal8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checker model: lock from en-cycle lockFrom, optional drop/abort/start
    // keyed to MEAS word index, one error word every 10th en-cycle.
    task automatic applyStimulus(input logic [31:0] wl, input int lockFrom,
                                 input int dropAt, input int dropLen,
                                 input int abortAt, input int startAt,
                                 input exp_t e, input int budget);
        int rstCycles = 0;
        int cyc = 0;
        int k, w;
        bit seenDone = 0;
        sb.push_back(e);
        windowLen = wl;
        start = 1'b1;
        tick();
        start = 1'b0;
        enCount = 0;
        while (cyc < budget) begin
            if (done) begin
                seenDone = 1;
                break;
            end
            if (chkReset && busy) rstCycles++;
            if (chkEn) begin
                k = enCount;
                enCount++;
                w = k - (lockFrom + 16);
                if (k == lockFrom + 17) checkOutput("measEntry", wordTotal, 1);
                lock   = (k >= lockFrom);
                if (dropAt >= 0 && w >= dropAt && w < dropAt + dropLen) lock = 1'b0;
                errNum = (k % 10 == 0) ? 8'd1 : 8'd0;
                abort  = (abortAt >= 0 && w == abortAt);
                start  = (startAt >= 0 && w == startAt);
            end else begin
                lock = 1'b0; errNum = '0; abort = 1'b0; start = 1'b0;
            end
            tick();
            cyc++;
        end
        lock = 1'b0; errNum = '0; abort = 1'b0; start = 1'b0;
        checkOutput("rstCycles", rstCycles, 2);
        if (!seenDone) begin
            checkOutput("doneTimeout", 0, 1);
            sb.delete();
        end
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("spuriousDone", done, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("status", status, e.status);
                    checkOutput("errTotal", errTotal, e.errs);
                    checkOutput("wordTotal", wordTotal, e.words);
                    checkOutput("enCycles", enCount, e.enCyc);
                    checkOutput("doneOutputs", {chkEn, chkReset, busy}, 0);
                end
            end
        end
    end

    initial begin : monitor8
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (done8) begin
                if (sb8.size() == 0) begin
                    checkOutput("spuriousDone8", done8, 0);
                end else begin
                    e = sb8.pop_front();
                    checkOutput("status8", status8, e.status);
                    checkOutput("errTotal8", errTotal8, e.errs);
                    checkOutput("wordTotal8", wordTotal8, e.words);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int cyc;
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; lock = 1'b0; errNum = '0; windowLen = '0;
        start8 = 1'b0; abort8 = 1'b0; lock8 = 1'b0; errNum8 = '0; windowLen8 = '0;
        tick();
        tick();
        checkOutput("resetOutputs", {busy, done, chkEn, chkReset}, 4'b0001);
        checkOutput("resetTotals", {status, errTotal, wordTotal}, 0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("idleChkReset", {busy, chkReset}, 2'b01);

        applyStimulus(100, 5, -1, 0, -1, 50, '{2'd0, 32'd10, 32'd100, 121}, 6000);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checkOutput("doneHold", {busy, status, wordTotal}, {1'b0, 2'd0, 32'd100});
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checkOutput("startWithAbort", {busy, wordTotal}, {1'b0, 32'd100});

        applyStimulus(100, 1 << 20, -1, 0, -1, -1, '{2'd1, 32'd0, 32'd0, 4096}, 6000);
        applyStimulus(100, 5, 40, 20, -1, -1, '{2'd2, 32'd5, 32'd56, 77}, 6000);
        applyStimulus(100, 5, -1, 0, 30, -1, '{2'd3, 32'd3, 32'd30, 52}, 6000);
        applyStimulus(0, 5, -1, 0, -1, -1, '{2'd0, 32'd0, 32'd0, 21}, 6000);

        sb8.push_back('{2'd0, 32'hFF, 32'd5, 0});
        windowLen8 = 8'd5;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lock8 = 1'b1;
        errNum8 = 8'hFF;
        cyc = 0;
        while (!done8 && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput("sat8Done", done8, 1);
        lock8 = 1'b0;
        errNum8 = '0;
        tick();

        windowLen = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!chkEn && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        checkOutput("midAcqBusy", busy, 1);
        reset = 1'b1;
        tick();
        checkOutput("midAcqReset", {busy, done, chkEn, chkReset}, 4'b0001);
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("afterResetIdle", {busy, done, status, wordTotal}, 0);

        checkOutput("sbDrained", sb.size(), 0);
        checkOutput("sb8Drained", sb8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
